// File: rtl/mem_stage.sv
// mem_stage -- memory-access stage sitting directly behind the EX/MEM register.
//
// Turns the registered memory command into a request/acknowledge transaction
// on the data bus, holds the pipeline with stallreq while the access is
// outstanding, and registers the writeback result toward WB. Accesses that
// never see an acknowledge are aborted after TIMEOUT BUSY cycles.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   mem_memrw          00 idle, 01 read, 10 write, 11 reserved (idle)
//   mem_memaddr        byte address (must be word aligned)
//   mem_memdata        store data
//   mem_wdata          ALU result for non-load instructions
//   mem_waddr, mem_we  destination register and its write enable
//   bus_req, bus_we    registered bus request / write strobe
//   bus_addr, bus_wdata registered bus address / store data
//   bus_rdata, bus_ack load data and single-cycle completion pulse
//   stallreq           combinational stall request to EX/MEM and upstream
//   bus_err            registered one-cycle pulse: timeout or misaligned
//   wb_wdata, wb_waddr, wb_we  registered writeback result
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_memrw,
  input  logic [31:0] mem_memaddr,
  input  logic [31:0] mem_memdata,
  input  logic [31:0] mem_wdata,
  input  logic [4:0]  mem_waddr,
  input  logic        mem_we,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stallreq,
  output logic        bus_err,
  output logic [31:0] wb_wdata,
  output logic [4:0]  wb_waddr,
  output logic        wb_we
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Counter value of the last BUSY cycle allowed before the abort.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        bus_req_reg, bus_req_next;
  logic        bus_we_reg, bus_we_next;
  logic [31:0] bus_addr_reg, bus_addr_next;
  logic [31:0] bus_wdata_reg, bus_wdata_next;
  logic        bus_err_reg, bus_err_next;
  logic [31:0] wb_wdata_reg, wb_wdata_next;
  logic [4:0]  wb_waddr_reg, wb_waddr_next;
  logic        wb_we_reg, wb_we_next;
  logic        stall_comb;

  logic is_rd, is_wr, is_acc, aligned, timeout_hit;

  assign is_rd       = (mem_memrw == 2'b01);
  assign is_wr       = (mem_memrw == 2'b10);
  assign is_acc      = is_rd | is_wr;
  assign aligned     = (mem_memaddr[1:0] == 2'b00);
  assign timeout_hit = (cnt_reg == LAST_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      bus_err_reg   <= 1'b0;
      wb_wdata_reg  <= '0;
      wb_waddr_reg  <= '0;
      wb_we_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bus_req_reg   <= bus_req_next;
      bus_we_reg    <= bus_we_next;
      bus_addr_reg  <= bus_addr_next;
      bus_wdata_reg <= bus_wdata_next;
      bus_err_reg   <= bus_err_next;
      wb_wdata_reg  <= wb_wdata_next;
      wb_waddr_reg  <= wb_waddr_next;
      wb_we_reg     <= wb_we_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bus_req_next   = bus_req_reg;
    bus_we_next    = bus_we_reg;
    bus_addr_next  = bus_addr_reg;
    bus_wdata_next = bus_wdata_reg;
    bus_err_next   = 1'b0;
    wb_wdata_next  = mem_wdata;
    wb_waddr_next  = mem_waddr;
    wb_we_next     = mem_we;
    stall_comb     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (is_acc && aligned) begin
          // Issue: launch the bus cycle and push a bubble toward WB.
          stall_comb     = 1'b1;
          state_next     = BUSY;
          cnt_next       = '0;
          bus_req_next   = 1'b1;
          bus_we_next    = is_wr;
          bus_addr_next  = mem_memaddr;
          bus_wdata_next = mem_memdata;
          wb_wdata_next  = '0;
          wb_waddr_next  = '0;
          wb_we_next     = 1'b0;
        end else if (is_acc) begin
          // Misaligned: no bus cycle, flag the error; a load returns zero.
          bus_err_next  = 1'b1;
          wb_wdata_next = is_wr ? mem_wdata : 32'h0;
        end
        // Idle/reserved commands fall through to the pass-through defaults.
      end

      BUSY: begin
        if (bus_ack || timeout_hit) begin
          // Completion or abort; the ack takes priority over the timeout.
          state_next   = IDLE;
          bus_req_next = 1'b0;
          bus_we_next  = 1'b0;
          bus_err_next = ~bus_ack;
          if (bus_we_reg)
            wb_wdata_next = mem_wdata;
          else
            wb_wdata_next = bus_ack ? bus_rdata : 32'h0;
        end else begin
          stall_comb    = 1'b1;
          cnt_next      = cnt_reg + 8'd1;
          wb_wdata_next = '0;
          wb_waddr_next = '0;
          wb_we_next    = 1'b0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Reset holds the pipeline free even though the state is IDLE already.
  assign stallreq  = rst ? stall_comb : 1'b0;

  assign bus_req   = bus_req_reg;
  assign bus_we    = bus_we_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_wdata = bus_wdata_reg;
  assign bus_err   = bus_err_reg;
  assign wb_wdata  = wb_wdata_reg;
  assign wb_waddr  = wb_waddr_reg;
  assign wb_we     = wb_we_reg;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipeline, directly downstream of the EX/MEM pipeline register. It takes the registered memory command and writeback data and performs loads and stores on the data bus through a request/acknowledge handshake. While an access is in flight it raises a stall request to the pipeline controller, and it registers the writeback result toward WB.

## Interface
Parameters:
- TIMEOUT, 255: maximum BUSY cycles before an access is aborted; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_memrw  in  2  memory command from EX/MEM: 00 idle, 01 read, 10 write, 11 reserved (treated as idle).
- mem_memaddr  in  32  byte address of the access.
- mem_memdata  in  32  store data.
- mem_wdata  in  32  ALU result for non-load instructions.
- mem_waddr  in  5  destination register.
- mem_we  in  1  register write enable.
- bus_req  out  1  data-bus request, registered.
- bus_we  out  1  1 = write access, registered.
- bus_addr  out  32  access address, registered.
- bus_wdata  out  32  store data, registered.
- bus_rdata  in  32  load data, valid when bus_ack = 1.
- bus_ack  in  1  single-cycle completion pulse.
- stallreq  out  1  combinational request to stall EX/MEM and the stages upstream of it.
- bus_err  out  1  single-cycle pulse on timeout or misaligned access, registered.
- wb_wdata  out  32  writeback data, registered.
- wb_waddr  out  5  writeback register, registered.
- wb_we  out  1  writeback enable, registered.

## Operation
- Two-state FSM: IDLE and BUSY. A cycle counter (8 bits) runs only in BUSY.
- **IDLE, idle or reserved command:** pass-through. At each edge, wb_wdata/wb_waddr/wb_we take mem_wdata/mem_waddr/mem_we. stallreq is 0.
- **IDLE, read or write with mem_memaddr[1:0] == 00:**
  - stallreq is 1.
  - At the edge: go to BUSY; bus_req=1; bus_we=(command==10); bus_addr=mem_memaddr; bus_wdata=mem_memdata; counter=0.
  - WB registers load a bubble (all zero).
- **IDLE, read or write with mem_memaddr[1:0] != 00:**
  - No bus access is issued; stallreq is 0.
  - At the edge: bus_err=1, wb_waddr/wb_we from the inputs.
  - wb_wdata takes 0 for a read and mem_wdata for a write.
- **BUSY, bus_ack=0 and counter < TIMEOUT-1:**
  - stallreq is 1; counter increments.
  - bus_* outputs are held stable; WB registers take a bubble.
- **BUSY, bus_ack=1:** stallreq is 0 in this same cycle, so EX/MEM advances at this edge. At the edge:
  - go to IDLE; bus_req=0, bus_we=0.
  - wb_waddr/wb_we take the inputs.
  - wb_wdata takes bus_rdata for a read and mem_wdata for a write.
- **BUSY, bus_ack=0 and counter == TIMEOUT-1:** abort. stallreq is 0 in this cycle. The edge behaves as the ack edge, except that read data is forced to 0 and bus_err=1.
- bus_ack and timeout in the same cycle: the ack wins and bus_err stays 0.
- bus_ack received in IDLE is ignored.
- bus_err is 0 on every edge not listed above.
- Inputs are guaranteed stable while stallreq=1, because EX/MEM is stalled.

## Timing
- Reset (rst=0): all registered outputs are 0, the FSM is in IDLE, the counter is 0, and stallreq is forced to 0.
- Reset is asynchronous. Asserting it mid-BUSY drops bus_req at once, without waiting for a clock edge. A late bus_ack after reset is ignored.
- Minimum access: 2 cycles (one IDLE issue cycle plus one BUSY cycle carrying the ack).
- For an ack in the Nth BUSY cycle:
  - stallreq is high for N cycles.
  - bus_req is high for N cycles.
  - The result is visible on wb_* in the cycle after the ack.
- On timeout, bus_req is high for exactly TIMEOUT cycles.
- Pass-through latency: 1 cycle.
- Back-to-back accesses: a new command enters IDLE on the cycle after the ack. bus_req is low for at least one cycle between accesses.

## Test plan
- **Reset:** hold rst=0 for 3 cycles with random inputs, then release. Required: all outputs 0 throughout reset, stallreq 0, and the first pass-through output one cycle after release.
- **Pass-through:** memrw=00, wdata=0x00001234, waddr=5, we=1. Required: next cycle wb_*=0x00001234/5/1, no bus_req, stallreq 0.
- **Load:** memrw=01, addr=0x00000100, waddr=8, we=1, ack in the 3rd BUSY cycle with rdata=0xDEADBEEF. Required:
  - stallreq high 3 cycles; bus_req high 3 cycles with bus_we=0.
  - wb_* show bubbles until wb_wdata=0xDEADBEEF, waddr=8, we=1 appear on the cycle after the ack.
- **Store:** memrw=10, addr=0x00000200, memdata=0xA5A5A5A5, we=0, ack in the 1st BUSY cycle. Required: bus_we=1, bus_wdata=0xA5A5A5A5, 2-cycle access, wb_we=0.
- **Timeout:** TIMEOUT=4, load with no ack. Required: bus_req high exactly 4 cycles, bus_err pulses 1 cycle, wb_wdata=0. A repeat with ack arriving in the 4th cycle gives no bus_err.
- **Misaligned and reset mid-access:**
  - Read at addr=0x00000102. Required: no bus_req, stallreq 0, bus_err pulse, wb_wdata=0.
  - Assert rst in the 2nd BUSY cycle of a load. Required: bus_req drops immediately; after release the FSM is in IDLE.
